rd_deserializer: RTL
====================

RD_DESERIALIZER -- requirements
Module: rd_deserializer

Interface
REQ-001 Parameter NCHAN, default 2, number of serial data lanes (1..4).
REQ-002 Parameter WORD_BITS, default 12, data bits per sample word (8..15).
REQ-003 Parameter NWORDS, default 2048, words per transfer (power of two, 16..8192).
REQ-004 Parameter WATCHDOG_CYCLES, default 65535, CLK120 cycles allowed from trigger to end of transfer.
REQ-005 Parameter HOLDOFF_CYCLES, default 25, CLK120 cycles during which triggers are blocked after a transfer ends.
REQ-006 Parameter TRIG_WIDTH, default 4, TRIG_OUT pulse length in CLK120 cycles.
REQ-007 CLK120  in  1  sole clock; all logic on its rising edge.
REQ-008 RST  in  1  asynchronous, active-high reset.
REQ-009 SERIAL_CLK_IN  in  1  RD transfer clock, asynchronous; sampled as data, at most CLK120/4.
REQ-010 SERIAL_DATA_IN  in  NCHAN  serial lanes; MSB first, parity bit last.
REQ-011 TRIG_IN  in  1  trigger from the trigger module, one-cycle pulse.
REQ-012 BUF_WNUM  in  2  current WCD write buffer number.
REQ-013 BUF_RNUM  in  2  current WCD read buffer number.
REQ-014 BUF_RELEASE  in  1  one-cycle pulse; clears the full flag of BUF_RELEASE_NUM.
REQ-015 BUF_RELEASE_NUM  in  2  buffer to release.
REQ-016 TRIG_OUT  out  1  trigger to RD.
REQ-017 STATUS  out  32  [3:0] full, [7:4] busy, [9:8] latched WNUM, [11:10] RNUM, [15:12] timeout, [16+4*buf+chan] parity error.
REQ-018 DATA_ADDR  out  32  byte address = buf*NWORDS*4 + word*4.
REQ-019 DATA_TO_MEM  out  16*NCHAN  lane c in [16c+15:16c]: data at [WORD_BITS:1], received parity bit at [0], remaining bits 0.
REQ-020 ENABLE_MEM_WRT  out  1  one-cycle write strobe qualifying DATA_ADDR/DATA_TO_MEM.

Function
REQ-021 SERIAL_CLK_IN and SERIAL_DATA_IN shall pass through a two-flop synchroniser each (equal delay); a sample is taken on the synchronised 0->1 SERIAL_CLK_IN transition.
REQ-022 States: IDLE, ARMED, XFER, HOLDOFF.
REQ-023 IDLE + TRIG_IN: latch BUF_WNUM into STATUS[9:8] and the active buffer, clear that buffer's timeout and parity bits, assert TRIG_OUT for TRIG_WIDTH cycles, load the watchdog, go to ARMED.
REQ-024 TRIG_IN in ARMED, XFER or HOLDOFF shall be ignored.
REQ-025 ARMED: the first serial clock edge sets the busy bit of the active buffer and is taken as bit 0 of word 0; go to XFER.
REQ-026 Each frame is WORD_BITS data bits then one parity bit; on the parity bit, DATA_TO_MEM/DATA_ADDR are updated and ENABLE_MEM_WRT pulses exactly one cycle, two cycles after that synchronised edge.
REQ-027 Word counter width is clog2(NWORDS); after word NWORDS-1 is written: busy cleared, full set, go to HOLDOFF.
REQ-028 Watchdog decrements every cycle in ARMED and XFER; at zero: timeout bit set, busy cleared, full not set, no further writes, go to HOLDOFF.
REQ-029 HOLDOFF counts HOLDOFF_CYCLES, ignoring serial edges, then returns to IDLE.
REQ-030 STATUS[11:10] shall follow BUF_RNUM with one cycle delay.
REQ-031 BUF_RELEASE in the same cycle as a full-set on the same buffer: set wins; on different buffers both take effect.

Reset
REQ-032 RST shall immediately force IDLE; STATUS, DATA_ADDR, DATA_TO_MEM, ENABLE_MEM_WRT, TRIG_OUT, and all counters and synchronisers to 0.
REQ-033 RST mid-transfer shall discard the partial word; no write strobe shall follow reset release until a new trigger.

Configuration
REQ-034 Macro RD_DESER_PARITY_EN defined: odd parity checked per lane (received parity bit equal to the XOR of data bits is an error), sticky in STATUS until the next trigger to that buffer.
REQ-035 RD_DESER_PARITY_EN undefined: frames are WORD_BITS bits with no parity bit, DATA_TO_MEM bit 0 of each lane is 0, STATUS[31:16] reads 0.

Verification
REQ-036 Defaults, TRIG_IN with BUF_WNUM=2, 2048 frames at 30 MHz -> TRIG_OUT high 4 cycles, 2048 strobes at addresses 0x4000..0x5FFC, STATUS[2]=1, STATUS[6]=0.
REQ-037 Lane 0 word 0xA5C with parity bit 0 (parity enabled) -> DATA_TO_MEM[15:0]=0x14B8, STATUS[16+4*buf]=1 at end of transfer.
REQ-038 Trigger then no serial clock -> after 65535 cycles STATUS[12+buf]=1, full bit 0, state IDLE 25 cycles later.
REQ-039 Second TRIG_IN 10 cycles after the last write -> TRIG_OUT stays low; TRIG_IN at 26 cycles -> accepted.
REQ-040 RST asserted after word 100 -> all outputs 0 immediately; ENABLE_MEM_WRT stays 0 despite continued serial clocks.
REQ-041 BUF_RELEASE on buffer 1 in the cycle buffer 1 becomes full -> STATUS[1]=1; release one cycle later -> STATUS[1]=0.

Source files
------------

// File: rtl/rd_deserializer_if.sv
// rd_deserializer_if: serial lanes, trigger/buffer control and memory-write bus of the RD deserializer.
interface rd_deserializer_if #(parameter int NCHAN = 2);
  logic                 serial_clk_i;
  logic [NCHAN-1:0]     serial_data_i;
  logic                 trig_in_i;
  logic [1:0]           buf_wnum_i;
  logic [1:0]           buf_rnum_i;
  logic                 buf_release_i;
  logic [1:0]           buf_release_num_i;
  logic                 trig_out_o;
  logic [31:0]          status_o;
  logic [31:0]          data_addr_o;
  logic [16*NCHAN-1:0]  data_to_mem_o;
  logic                 enable_mem_wrt_o;
  modport master (
    output serial_clk_i, serial_data_i, trig_in_i, buf_wnum_i, buf_rnum_i, buf_release_i, buf_release_num_i,
    input  trig_out_o, status_o, data_addr_o, data_to_mem_o, enable_mem_wrt_o
  );
  modport slave (
    input  serial_clk_i, serial_data_i, trig_in_i, buf_wnum_i, buf_rnum_i, buf_release_i, buf_release_num_i,
    output trig_out_o, status_o, data_addr_o, data_to_mem_o, enable_mem_wrt_o
  );
endinterface

// File: rtl/rd_deserializer.sv
// rd_deserializer: captures RD serial lanes into WCD buffers with watchdog and trigger holdoff.
// Define RD_DESER_PARITY_EN to receive and check a trailing odd-parity bit per frame.
module rd_deserializer #(
  parameter int NCHAN           = 2,
  parameter int WORD_BITS       = 12,
  parameter int NWORDS          = 2048,
  parameter int WATCHDOG_CYCLES = 65535,
  parameter int HOLDOFF_CYCLES  = 25,
  parameter int TRIG_WIDTH      = 4
) (
  input logic clk120_i,
  input logic rst_i,
  rd_deserializer_if.slave bus
);
`ifdef RD_DESER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB = WORD_BITS + PAR;
  localparam int AW = $clog2(NWORDS);
  localparam int BW = $clog2(FB);
  localparam int DW = $clog2(WATCHDOG_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int TW = $clog2(TRIG_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ARMED, XFER, HOLDOFF} state_t;
  state_t state_q, state_d;
  logic [1:0] sclk_q;
  logic sclk_p_q;
  logic [1:0][NCHAN-1:0] sdat_q;
  logic [NCHAN-1:0][FB-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [AW-1:0] word_q, word_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [HW-1:0] ho_q, ho_d;
  logic [TW-1:0] tr_q, tr_d;
  logic wr_p_q, wr_p_d;
  logic [1:0] act_q, act_d, rnum_q;
  logic [3:0] full_q, full_d, busy_q, busy_d, tmo_q, tmo_d;
  logic [15:0] perr_q, perr_d, perr_new;
  logic [31:0] addr_q, addr_d;
  logic [16*NCHAN-1:0] dat_q, dat_d, lane_dat;
  logic en_q, en_d;
  logic rise, last_bit, run;
  assign rise = sclk_q[1] & ~sclk_p_q;
  assign last_bit = bit_q == BW'(FB - 1);
  assign run = state_q == ARMED || state_q == XFER;
  // Memory word layout: data above bit 0, received parity (or 0) in bit 0.
  always_comb begin
    lane_dat = '0;
    perr_new = '0;
    for (int c = 0; c < NCHAN; c++) begin
`ifdef RD_DESER_PARITY_EN
      lane_dat[16*c +: 16] = 16'(sh_q[c]);
      perr_new[{act_q, 2'(c)}] = sh_q[c][0] == ^sh_q[c][FB-1:1];
`else
      lane_dat[16*c +: 16] = 16'({sh_q[c], 1'b0});
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    bit_d = bit_q;
    word_d = word_q;
    wd_d = run ? wd_q - DW'(1) : wd_q;
    ho_d = ho_q;
    tr_d = (tr_q == '0) ? '0 : tr_q - TW'(1);
    wr_p_d = 1'b0;
    act_d = act_q;
    full_d = full_q;
    busy_d = busy_q;
    tmo_d = tmo_q;
    perr_d = perr_q;
    addr_d = addr_q;
    dat_d = dat_q;
    en_d = 1'b0;
    if (bus.buf_release_i) full_d[bus.buf_release_num_i] = 1'b0;
    if (rise && run) begin
      for (int c = 0; c < NCHAN; c++) sh_d[c] = {sh_q[c][FB-2:0], sdat_q[1][c]};
      bit_d = last_bit ? '0 : bit_q + BW'(1);
      wr_p_d = last_bit;
    end
    // Watchdog expiry aborts the transfer, dropping any word still in flight.
    if (run && wd_q == '0) begin
      tmo_d[act_q] = 1'b1;
      busy_d[act_q] = 1'b0;
      wr_p_d = 1'b0;
      ho_d = HW'(HOLDOFF_CYCLES - 1);
      state_d = HOLDOFF;
    end else begin
      case (state_q)
        IDLE: if (bus.trig_in_i) begin
          act_d = bus.buf_wnum_i;
          tmo_d[bus.buf_wnum_i] = 1'b0;
          perr_d[4*bus.buf_wnum_i +: 4] = '0;
          tr_d = TW'(TRIG_WIDTH);
          wd_d = DW'(WATCHDOG_CYCLES);
          bit_d = '0;
          word_d = '0;
          state_d = ARMED;
        end
        ARMED: if (rise) begin
          busy_d[act_q] = 1'b1;
          state_d = XFER;
        end
        XFER: if (wr_p_q) begin
          en_d = 1'b1;
          addr_d = (32'(act_q) << (AW + 2)) | (32'(word_q) << 2);
          dat_d = lane_dat;
          perr_d = perr_q | perr_new;
          word_d = word_q + AW'(1);
          if (word_q == '1) begin
            full_d[act_q] = 1'b1;
            busy_d[act_q] = 1'b0;
            ho_d = HW'(HOLDOFF_CYCLES - 1);
            state_d = HOLDOFF;
          end
        end
        HOLDOFF: begin
          ho_d = ho_q - HW'(1);
          state_d = (ho_q == '0) ? IDLE : HOLDOFF;
        end
      endcase
    end
  end
  always_ff @(posedge clk120_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sclk_q <= '0;
      sclk_p_q <= 1'b0;
      sdat_q <= '0;
      sh_q <= '0;
      bit_q <= '0;
      word_q <= '0;
      wd_q <= '0;
      ho_q <= '0;
      tr_q <= '0;
      wr_p_q <= 1'b0;
      act_q <= '0;
      rnum_q <= '0;
      full_q <= '0;
      busy_q <= '0;
      tmo_q <= '0;
      perr_q <= '0;
      addr_q <= '0;
      dat_q <= '0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_q <= {sclk_q[0], bus.serial_clk_i};
      sclk_p_q <= sclk_q[1];
      sdat_q <= {sdat_q[0], bus.serial_data_i};
      sh_q <= sh_d;
      bit_q <= bit_d;
      word_q <= word_d;
      wd_q <= wd_d;
      ho_q <= ho_d;
      tr_q <= tr_d;
      wr_p_q <= wr_p_d;
      act_q <= act_d;
      rnum_q <= bus.buf_rnum_i;
      full_q <= full_d;
      busy_q <= busy_d;
      tmo_q <= tmo_d;
      perr_q <= perr_d;
      addr_q <= addr_d;
      dat_q <= dat_d;
      en_q <= en_d;
    end
  end
  assign bus.trig_out_o = tr_q != '0;
  assign bus.status_o = {perr_q, tmo_q, rnum_q, act_q, busy_q, full_q};
  assign bus.data_addr_o = addr_q;
  assign bus.data_to_mem_o = dat_q;
  assign bus.enable_mem_wrt_o = en_q;
endmodule
